// File: rtl/wf_random_timer_pkg.sv
// Shared types and widths for the random delay timer.
package wf_random_timer_pkg;
   localparam int CNT_W = 7;   // tick count width (N max 31 + 31 = 62)
   localparam int RND_W = 5;   // upstream random generator width

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_COUNT = 3'd3,
      ST_FIRE  = 3'd4
   } state_t;
endpackage

// File: rtl/wf_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE clocks while not cleared.
module wf_tick_gen #(
   parameter int PRESCALE = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);
   localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

   logic [W-1:0] cnt;

   // Free-running 0..PRESCALE-1 counter, held at 0 while cleared
   always_ff @(posedge clk) begin
      if (reset || clear)  cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + W'(1);
   end

   // Tick is suppressed while cleared so PRESCALE=1 does not tick outside COUNT
   assign tick = !clear && (cnt == LAST);
endmodule

// File: rtl/wf_random_timer.sv
// Random delay timer: on start, pulls one value from the upstream PRNG,
// waits (rnd_data + MIN_TICKS) * PRESCALE clocks, then pulses fire.
// Optional macro WF_RANDOM_TIMER_REPEAT_EN: after fire, immediately
// request a new random delay (free-running) until cancel or reset.
module wf_random_timer
   import wf_random_timer_pkg::*;
#(
   parameter int PRESCALE  = 1000,
   parameter int MIN_TICKS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cancel,
   input  logic [RND_W-1:0] rnd_data,
   output logic             rnd_enable,
   output logic             busy,
   output logic             fire,
   output logic [CNT_W-1:0] delay
);
   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] n_val;
   logic             tick;
   logic             pre_clear;

   // N never overflows 7 bits: 31 + 31 = 62
   assign n_val     = CNT_W'(rnd_data) + CNT_W'(MIN_TICKS);
   // Holding the prescaler clear outside COUNT guarantees it starts at 0 on entry
   assign pre_clear = (state != ST_COUNT);

   wf_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (pre_clear),
      .tick  (tick)
   );

   // Control FSM with registered outputs; pulses default low every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         remaining  <= '0;
         rnd_enable <= 1'b0;
         busy       <= 1'b0;
         fire       <= 1'b0;
         delay      <= '0;
      end else begin
         rnd_enable <= 1'b0;
         fire       <= 1'b0;
         case (state)
            ST_IDLE: begin
               // cancel wins over a simultaneous start
               if (start && !cancel) begin
                  state      <= ST_REQ;
                  rnd_enable <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_REQ: begin
               if (cancel) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (cancel) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  delay     <= n_val;
                  remaining <= n_val;
                  if (n_val == '0) begin
                     state <= ST_FIRE;
                     fire  <= 1'b1;
                  end else begin
                     state <= ST_COUNT;
                  end
               end
            end
            ST_COUNT: begin
               // cancel takes priority over a tick in the same cycle
               if (cancel) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (tick) begin
                  if (remaining == CNT_W'(1)) begin
                     state     <= ST_FIRE;
                     fire      <= 1'b1;
                     remaining <= '0;
                  end else begin
                     remaining <= remaining - CNT_W'(1);
                  end
               end
            end
            ST_FIRE: begin
`ifdef WF_RANDOM_TIMER_REPEAT_EN
               if (cancel) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state      <= ST_REQ;
                  rnd_enable <= 1'b1;
               end
`else
               state <= ST_IDLE;
               busy  <= 1'b0;
`endif
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wf_random_timer.sv
// Bench for wf_random_timer: two instances (PRESCALE=4/MIN_TICKS=1 and
// PRESCALE=3/MIN_TICKS=0) driven by shared stimulus, checked every cycle
// against a timeline model plus directed latency checks.
module tb_wf_random_timer;
   localparam int INF = 1 << 30;
   localparam int PS[2] = '{4, 3};
   localparam int MT[2] = '{1, 0};

   logic       clk = 1'b0;
   logic       reset, start, cancel;
   logic [4:0] rnd_data;
   logic       rne [2];
   logic       bsy [2];
   logic       fir [2];
   logic [6:0] dly [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // timeline model: active flag, cycle start was sampled, cycle fire is due
   bit act [2];
   int t0  [2];
   int fa  [2];
   int mdl [2];

   // observation bookkeeping for directed checks
   int win_fire [2];
   int win_rne  [2];
   int first_fire [2];
   int last_rne   [2];

   always #5 clk = ~clk;

   wf_random_timer #(.PRESCALE(4), .MIN_TICKS(1)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .cancel(cancel), .rnd_data(rnd_data),
      .rnd_enable(rne[0]), .busy(bsy[0]), .fire(fir[0]), .delay(dly[0]));

   wf_random_timer #(.PRESCALE(3), .MIN_TICKS(0)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .cancel(cancel), .rnd_data(rnd_data),
      .rnd_enable(rne[1]), .busy(bsy[1]), .fire(fir[1]), .delay(dly[1]));

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // advance the model by one sampled cycle c with the given inputs
   task automatic model(input int c, input bit st, input bit ca, input bit rs, input int rd);
      for (int i = 0; i < 2; i++) begin
         if (rs) begin
            act[i] = 0;
            mdl[i] = 0;
         end else if (act[i]) begin
            if (ca && c < fa[i]) begin
               act[i] = 0;
            end else if (c == t0[i] + 2) begin
               mdl[i] = rd + MT[i];
               fa[i]  = t0[i] + 3 + mdl[i] * PS[i];
            end else if (c == fa[i]) begin
`ifdef WF_RANDOM_TIMER_REPEAT_EN
               if (ca) act[i] = 0;
               else begin
                  t0[i] = c;
                  fa[i] = INF;
               end
`else
               act[i] = 0;
`endif
            end
         end else if (st && !ca) begin
            act[i] = 1;
            t0[i]  = c;
            fa[i]  = INF;
         end
      end
   endtask

   task automatic open_win();
      for (int i = 0; i < 2; i++) begin
         win_fire[i]   = 0;
         win_rne[i]    = 0;
         first_fire[i] = -1;
         last_rne[i]   = -1;
      end
   endtask

   // one clock: drive inputs, let the edge happen, compare all outputs
   task automatic step(input bit st, input bit ca, input bit rs, input logic [4:0] rd);
      start = st; cancel = ca; reset = rs; rnd_data = rd;
      @(posedge clk);
      #1;
      model(cyc, st, ca, rs, int'(rd));
      cyc++;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rnd_enable%0d", i), int'(rne[i]), int'(act[i] && cyc == t0[i] + 1));
         check($sformatf("busy%0d", i),       int'(bsy[i]), int'(act[i]));
         check($sformatf("fire%0d", i),       int'(fir[i]), int'(act[i] && cyc == fa[i]));
         check($sformatf("delay%0d", i),      int'(dly[i]), mdl[i]);
         if (fir[i] === 1'b1) begin
            win_fire[i]++;
            if (first_fire[i] < 0) first_fire[i] = cyc;
         end
         if (rne[i] === 1'b1) begin
            win_rne[i]++;
            last_rne[i] = cyc;
         end
      end
   endtask

   task automatic go_idle();
      step(0, 1, 0, 5'd0);
      step(0, 1, 0, 5'd0);
      step(0, 0, 0, 5'd0);
   endtask

   initial begin
      int s;
      for (int i = 0; i < 2; i++) begin
         act[i] = 0; t0[i] = 0; fa[i] = INF; mdl[i] = 0;
      end
      open_win();

      // reset, including reset with start and cancel asserted
      step(0, 0, 1, 5'd0);
      step(1, 1, 1, 5'd7);
      step(1, 0, 1, 5'd9);
      check("reset_busy", int'(bsy[0]), 0);
      check("reset_delay", int'(dly[0]), 0);
      step(0, 0, 0, 5'd0);

      // basic latency: PRESCALE=4, N=3+1=4 -> fire at cycle 19
      open_win();
      s = cyc;
      step(1, 0, 0, 5'h03);
      for (int k = 1; k < 20; k++) step(0, 0, 0, 5'h03);
      check("lat_rne_cycle", last_rne[0] - s, 1);
      check("lat_fire_cycle", first_fire[0] - s, 19);
      check("lat_fire_count", win_fire[0], 1);
      check("lat_delay", int'(dly[0]), 4);
      go_idle();

      // N=0 on the MIN_TICKS=0 instance -> fire at cycle 3
      open_win();
      s = cyc;
      step(1, 0, 0, 5'h00);
      for (int k = 1; k < 5; k++) step(0, 0, 0, 5'h00);
      check("zero_fire_cycle", first_fire[1] - s, 3);
      check("zero_delay", int'(dly[1]), 0);
      go_idle();

      // cancel at cycle 10, restart at cycle 12
      open_win();
      s = cyc;
      step(1, 0, 0, 5'h03);
      for (int k = 1; k < 10; k++) step(0, 0, 0, 5'h03);
      step(0, 1, 0, 5'h03);
      check("cancel_busy", int'(bsy[0]), 0);
      step(0, 0, 0, 5'h03);
      check("cancel_no_fire", win_fire[0], 0);
      step(1, 0, 0, 5'h03);
      check("restart_rne_cycle", last_rne[0] - s, 13);
      go_idle();

      // extra starts at cycles 5 and 8 are ignored
      open_win();
      s = cyc;
      step(1, 0, 0, 5'h03);
      for (int k = 1; k < 19; k++) step(k == 5 || k == 8, 0, 0, 5'h03);
      check("spam_rne_count", win_rne[0], 1);
      check("spam_fire_cycle", first_fire[0] - s, 19);
      go_idle();

      // reset mid-COUNT at cycle 8
      open_win();
      s = cyc;
      step(1, 0, 0, 5'h03);
      for (int k = 1; k < 8; k++) step(0, 0, 0, 5'h03);
      step(0, 0, 1, 5'h03);
      check("rst_mid_busy", int'(bsy[0]), 0);
      check("rst_mid_delay", int'(dly[0]), 0);
      for (int k = 9; k < 30; k++) step(0, 0, 0, 5'h03);
      check("rst_mid_no_fire", win_fire[0], 0);

`ifdef WF_RANDOM_TIMER_REPEAT_EN
      // free-running: fire 19, next request at 20, next fire 22 + N'*4
      open_win();
      s = cyc;
      step(1, 0, 0, 5'h03);
      for (int k = 1; k < 21; k++) step(0, 0, 0, (k >= 20) ? 5'h05 : 5'h03);
      check("rep_fire1", first_fire[0] - s, 19);
      check("rep_rne2", last_rne[0] - s, 20);
      first_fire[0] = -1;
      for (int k = 21; k < 50; k++) step(0, 0, 0, 5'h05);
      check("rep_fire2", first_fire[0] - s, 22 + 6 * 4);
      go_idle();
`endif

      // randomized traffic checked against the model every cycle
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(7) == 0), ($urandom_range(39) == 0),
              ($urandom_range(299) == 0), 5'($urandom_range(31)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wf_random_timer.md
WF_RANDOM_TIMER -- requirements
Module: wf_random_timer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 1000: clk cycles per delay tick, range 1..65535.
REQ-002 The block SHALL have parameter MIN_TICKS, default 1: constant added to the random value, range 0..31.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request one random delay, sampled only in IDLE.
REQ-006 The block SHALL have port cancel, input, 1 bit: abort any delay in progress.
REQ-007 The block SHALL have port rnd_data, input, 5 bits: value from the upstream 5-bit pseudo-random generator.
REQ-008 The block SHALL have port rnd_enable, output, 1 bit: one-cycle advance strobe to that generator's enable.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 The block SHALL have port fire, output, 1 bit: one-cycle pulse when the delay expires.
REQ-011 The block SHALL have port delay, output, 7 bits: the tick count N loaded for the current or last delay.

Function
REQ-012 The block SHALL implement states IDLE, REQ, LOAD, COUNT and FIRE, and all outputs SHALL be registered.
REQ-013 In IDLE, start=1 SHALL move the state to REQ; otherwise it SHALL stay in IDLE.
REQ-014 In REQ, rnd_enable SHALL be 1 for exactly that cycle and the state SHALL move to LOAD.
REQ-015 In LOAD, the block SHALL set N = rnd_data + MIN_TICKS, computed 7-bit with no overflow (max 62), and copy N to delay.
REQ-016 In LOAD, the state SHALL move to FIRE if N=0, otherwise to COUNT.
REQ-017 In COUNT, the prescaler SHALL be cleared on entry and count 0..PRESCALE-1; a tick SHALL occur at count PRESCALE-1, after which the prescaler wraps to 0.
REQ-018 Each tick SHALL decrement the remaining count; the tick that takes it to 0 SHALL move the state to FIRE.
REQ-019 The latency SHALL be: start sampled at cycle 0, rnd_enable=1 at cycle 1, fire=1 at cycle 3+N*PRESCALE.
REQ-020 In FIRE, fire SHALL be 1 for that single cycle and the next state SHALL be IDLE (see REQ-026).
REQ-021 start SHALL be ignored in every state other than IDLE, with no queuing.
REQ-022 cancel=1 in REQ, LOAD or COUNT SHALL move the state to IDLE on the next edge with no fire; cancel SHALL take priority over a simultaneous tick.
REQ-023 cancel=1 in FIRE SHALL NOT suppress the fire pulse already on the output; cancel in IDLE SHALL take priority over start.

Reset
REQ-024 reset=1 SHALL force state IDLE, prescaler 0, count 0, rnd_enable 0, busy 0, fire 0 and delay 0 on the next edge, from any state.
REQ-025 reset SHALL take priority over start and cancel.

Configuration
REQ-026 With macro WF_RANDOM_TIMER_REPEAT_EN defined, FIRE SHALL go to REQ instead of IDLE (free-running random pulses until cancel or reset); without it, FIRE SHALL go to IDLE.

Structure
REQ-027 Package wf_random_timer_pkg SHALL hold the state enum, the count width constant (7) and the random width constant (5).
REQ-028 The prescaler SHALL be one sub-module, wf_tick_gen, with inputs clk, reset and clear, parameter PRESCALE, and a 1-cycle tick output.

Verification
REQ-029 Bench: PRESCALE=4, MIN_TICKS=1, rnd_data=5'h03, start at cycle 0 -> rnd_enable=1 at cycle 1, delay=4, fire=1 at cycle 19 only.
REQ-030 Bench: MIN_TICKS=0, rnd_data=0, start -> delay=0, fire=1 at cycle 3, busy=0 at cycle 4.
REQ-031 Bench: PRESCALE=4, N=4, cancel at cycle 10 -> busy=0 at cycle 11, no fire; a new start at cycle 12 -> rnd_enable=1 at cycle 13.
REQ-032 Bench: start pulsed at cycles 5 and 8 during an active delay -> no extra rnd_enable and fire timing unchanged.
REQ-033 Bench: reset at cycle 8 mid-COUNT -> all outputs 0 at cycle 9, no fire thereafter.
REQ-034 Bench with WF_RANDOM_TIMER_REPEAT_EN: N=4, PRESCALE=4 -> fire at cycle 19, rnd_enable=1 at cycle 20, next fire at cycle 22+N'*4.
